// File: rtl/alu_pkg.sv
// Shared definitions for the arithmetic datapath: operand-buffer state
// encoding and the S1S0 select codes that choose the adder's Y operand.
package alu_pkg;

   // Occupancy of the two-entry operand buffer (output register + skid).
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } buf_state_e;

   // S1S0 select codes for the B-input logic.
   localparam logic [1:0] YSEL_ZERO  = 2'b00;
   localparam logic [1:0] YSEL_B     = 2'b01;
   localparam logic [1:0] YSEL_NOT_B = 2'b10;
   localparam logic [1:0] YSEL_ONES  = 2'b11;

endpackage

// File: rtl/b_input_logic.sv
// B-input logic: maps operand B and the S1S0 select to the adder Y operand.
module b_input_logic
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] b_i,
   input  logic [1:0]       sel_i,
   output logic [WIDTH-1:0] y_o
);

   // Select zeros, B, ~B or ones for the Y operand.
   always_comb begin
      y_o = '0;
      case (sel_i)
         YSEL_ZERO:  y_o = '0;
         YSEL_B:     y_o = b_i;
         YSEL_NOT_B: y_o = ~b_i;
         YSEL_ONES:  y_o = '1;
         default:    y_o = '0;
      endcase
   end

endmodule

// File: rtl/arith_operand_stage.sv
// Operand stage in front of the parallel adder. Forms the Y operand from B
// and the select, then holds {A, Y, Cin} in a two-entry buffer (output
// register plus skid register) so in_ready can come straight from a flop.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Output data is held while out_valid=1 and out_ready=0. in_ready
// depends only on registered state, never on out_ready in the same cycle.
module arith_operand_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_y,
   output logic             out_cin,
   output logic [1:0]       dbg_state
);

   buf_state_e       state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic [WIDTH-1:0] out_a_q, out_a_d, out_y_q, out_y_d;
   logic             out_cin_q, out_cin_d;
   logic [WIDTH-1:0] skid_a_q, skid_a_d, skid_y_q, skid_y_d;
   logic             skid_cin_q, skid_cin_d;
   logic [WIDTH-1:0] new_y;
   logic             in_xfer, out_xfer;

   b_input_logic #(.WIDTH(WIDTH)) u_b_input_logic (
      .b_i   (in_b),
      .sel_i (in_sel[2:1]),
      .y_o   (new_y)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_a     = out_a_q;
   assign out_y     = out_y_q;
   assign out_cin   = out_cin_q;
   assign dbg_state = state_q;
   assign in_xfer   = in_valid & in_ready_q;
   assign out_xfer  = out_valid & out_ready;

   // Next buffer state and data movement for each occupancy/transfer combination.
   always_comb begin
      state_d    = state_q;
      out_a_d    = out_a_q;
      out_y_d    = out_y_q;
      out_cin_d  = out_cin_q;
      skid_a_d   = skid_a_q;
      skid_y_d   = skid_y_q;
      skid_cin_d = skid_cin_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               state_d   = ST_ONE;
               out_a_d   = in_a;
               out_y_d   = new_y;
               out_cin_d = in_sel[0];
            end
         end
         ST_ONE: begin
            if (in_xfer && out_xfer) begin
               out_a_d   = in_a;
               out_y_d   = new_y;
               out_cin_d = in_sel[0];
            end else if (in_xfer) begin
               state_d    = ST_FULL;
               skid_a_d   = in_a;
               skid_y_d   = new_y;
               skid_cin_d = in_sel[0];
            end else if (out_xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only the drain can happen.
            if (out_xfer) begin
               state_d   = ST_ONE;
               out_a_d   = skid_a_q;
               out_y_d   = skid_y_q;
               out_cin_d = skid_cin_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      in_ready_d = (state_d != ST_FULL);
   end

   // Buffer registers; reset clears everything and reopens the input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         out_a_q    <= '0;
         out_y_q    <= '0;
         out_cin_q  <= 1'b0;
         skid_a_q   <= '0;
         skid_y_q   <= '0;
         skid_cin_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         out_a_q    <= out_a_d;
         out_y_q    <= out_y_d;
         out_cin_q  <= out_cin_d;
         skid_a_q   <= skid_a_d;
         skid_y_q   <= skid_y_d;
         skid_cin_q <= skid_cin_d;
      end
   end

endmodule

// File: tb/tb_arith_operand_stage.sv
// Bench for arith_operand_stage: directed operand sets with hand-computed Y
// values, a scoreboard queue of {A, Y, Cin}, and a negedge monitor.
module tb_arith_operand_stage;
   import alu_pkg::*;

   localparam int W = 32;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [2:0]    in_sel;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_a;
   logic [W-1:0]  out_y;
   logic          out_cin;
   logic [1:0]    dbg_state;

   logic [2*W:0]  exp_q[$];
   int            n_checks;
   int            n_fail;
   int            n_pops;
   int            n_stalls;

   arith_operand_stage #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_y     (out_y),
      .out_cin   (out_cin),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // ---------------- driver ----------------
   // Present one operand set starting at posedge+1; it counts as accepted at
   // the first edge where in_ready is seen high at the preceding negedge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] sel, input logic [W-1:0] ey);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_sel   = sel;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n_stalls++;
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("send_timeout", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
      end else begin
         exp_q.push_back({a, ey, sel[0]});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = $urandom;
      in_b     = $urandom;
      in_sel   = 3'($urandom_range(0, 7));
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
      end
      #1;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [2*W:0] e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", {{W{1'b0}}, out_valid}, '0);
         end else begin
            e = exp_q.pop_front();
            n_pops++;
            check("out_a", {1'b0, out_a}, {1'b0, e[2*W:W+1]});
            check("out_y", {1'b0, out_y}, {1'b0, e[W:1]});
            check("out_cin", {{W{1'b0}}, out_cin}, {{W{1'b0}}, e[0]});
         end
      end
   end

   // ---------------- directed vectors ----------------
   logic [W-1:0] va[8];
   logic [W-1:0] vb[8];
   logic [2:0]   vs[8];
   logic [W-1:0] vy[8];

   initial begin
      va[0] = 32'h0000_0001; vb[0] = 32'h0000_FFFF; vs[0] = 3'b011; vy[0] = 32'h0000_FFFF;
      va[1] = 32'h1111_1111; vb[1] = 32'h0F0F_0F0F; vs[1] = 3'b100; vy[1] = 32'hF0F0_F0F0;
      va[2] = 32'h2222_2222; vb[2] = 32'h1234_5678; vs[2] = 3'b000; vy[2] = 32'h0000_0000;
      va[3] = 32'h3333_3333; vb[3] = 32'h1234_5678; vs[3] = 3'b111; vy[3] = 32'hFFFF_FFFF;
      va[4] = 32'h4444_4444; vb[4] = 32'h8000_0000; vs[4] = 3'b101; vy[4] = 32'h7FFF_FFFF;
      va[5] = 32'h5555_5555; vb[5] = 32'hCAFE_F00D; vs[5] = 3'b010; vy[5] = 32'hCAFE_F00D;
      va[6] = 32'h6666_6666; vb[6] = 32'hFFFF_0000; vs[6] = 3'b001; vy[6] = 32'h0000_0000;
      va[7] = 32'hFFFF_FFFF; vb[7] = 32'h0000_0000; vs[7] = 3'b100; vy[7] = 32'hFFFF_FFFF;
   end

   // ---------------- main sequence ----------------
   initial begin
      int p0;
      n_checks  = 0;
      n_fail    = 0;
      n_pops    = 0;
      n_stalls  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sel    = '0;
      out_ready = 1'b0;
      cycles(3);

      // Reset state
      check("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
      check("rst_out_a", {1'b0, out_a}, '0);
      check("rst_out_y", {1'b0, out_y}, '0);
      check("rst_out_cin", {{W{1'b0}}, out_cin}, '0);
      check("rst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
      check("rst_state", {{(W-1){1'b0}}, dbg_state}, {{(W-1){1'b0}}, ST_EMPTY});
      rst_n = 1'b1;
      cycles(2);

      // Add with no carry: Y = B, one-cycle latency
      out_ready = 1'b1;
      send(32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0001);
      check("latency_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
      // Subtract: Y = ~B with carry-in
      send(32'h0000_0005, 32'h0000_0003, 3'b101, 32'hFFFF_FFFC);
      // Ones select then zero select with carry
      send(32'h1234_5678, 32'hA5A5_A5A5, 3'b110, 32'hFFFF_FFFF);
      send(32'h0000_0000, 32'hDEAD_BEEF, 3'b001, 32'h0000_0000);
      cycles(2);
      check("drain_empty", {{W{1'b0}}, out_valid}, '0);

      // Backpressure: fill both entries
      out_ready = 1'b0;
      send(32'hAAAA_0001, 32'h0000_00F0, 3'b010, 32'h0000_00F0);
      send(32'hBBBB_0002, 32'h0000_000F, 3'b100, 32'hFFFF_FFF0);
      check("full_in_ready", {{W{1'b0}}, in_ready}, '0);
      check("full_state", {{(W-1){1'b0}}, dbg_state}, {{(W-1){1'b0}}, ST_FULL});
      for (int i = 0; i < 3; i++) begin
         cycles(1);
         check("hold_a", {1'b0, out_a}, {1'b0, 32'hAAAA_0001});
         check("hold_y", {1'b0, out_y}, {1'b0, 32'h0000_00F0});
      end
      out_ready = 1'b1;
      cycles(1);
      check("drain_next_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
      check("drain_next_a", {1'b0, out_a}, {1'b0, 32'hBBBB_0002});
      check("reopen_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
      cycles(2);

      // Throughput: 8 back-to-back sets
      p0 = n_pops;
      n_stalls = 0;
      for (int i = 0; i < 8; i++) begin
         send(va[i], vb[i], vs[i], vy[i]);
      end
      @(negedge clk);
      #1;
      check("b2b_pops", {1'b0, 32'(n_pops - p0)}, {1'b0, 32'd8});
      check("b2b_stalls", {1'b0, 32'(n_stalls)}, '0);
      cycles(2);

      // Asynchronous reset while FULL
      out_ready = 1'b0;
      send(32'hCCCC_0003, 32'h0000_1234, 3'b011, 32'h0000_1234);
      send(32'hDDDD_0004, 32'h0000_5678, 3'b010, 32'h0000_5678);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("arst_out_valid", {{W{1'b0}}, out_valid}, '0);
      check("arst_out_a", {1'b0, out_a}, '0);
      check("arst_out_y", {1'b0, out_y}, '0);
      check("arst_out_cin", {{W{1'b0}}, out_cin}, '0);
      check("arst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
      cycles(1);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycles(1);
         check("post_rst_no_stale", {{W{1'b0}}, out_valid}, '0);
      end
      send(32'hEEEE_0005, 32'h0000_0009, 3'b101, 32'hFFFF_FFF6);
      check("post_rst_state", {{(W-1){1'b0}}, dbg_state}, {{(W-1){1'b0}}, ST_ONE});
      cycles(3);

      check("queue_empty", {1'b0, 32'(exp_q.size())}, '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/arith_operand_stage.md
ARITH_OPERAND_STAGE -- requirements
Module: arith_operand_stage

Interface
REQ-001: The module SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002: Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-003: Port rst_n, input, 1, is the asynchronous active-low reset.
REQ-004: Port in_valid, input, 1, means the upstream operand set is valid.
REQ-005: Port in_ready, output, 1, means the stage accepts an operand set this cycle.
REQ-006: Port in_a, input, WIDTH, is operand A.
REQ-007: Port in_b, input, WIDTH, is operand B.
REQ-008: Port in_sel, input, 3, is the arithmetic select {S1,S0,Cin}.
REQ-009: Port out_valid, output, 1, means the registered adder operands are valid.
REQ-010: Port out_ready, input, 1, means the downstream parallel adder stage consumes this cycle.
REQ-011: Port out_a, output, WIDTH, is the A operand to the parallel adder.
REQ-012: Port out_y, output, WIDTH, is the Y operand to the parallel adder.
REQ-013: Port out_cin, output, 1, is the carry-in to the parallel adder.

Function
REQ-014: An input transfer SHALL occur when in_valid and in_ready are both 1 at a rising edge; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-015: B-input logic SHALL apply: S1S0=00 gives Y all-zeros, 01 gives Y=in_b, 10 gives Y=~in_b, 11 gives Y all-ones.
REQ-016: out_cin SHALL equal in_sel[0] of the same transfer; out_a SHALL equal in_a unmodified.
REQ-017: Latency SHALL be exactly 1 cycle from input transfer to out_valid when the output register is empty or draining.
REQ-018: The stage SHALL be a 2-entry buffer: output register plus one skid register; states EMPTY (0 held), ONE (output only), FULL (output and skid).
REQ-019: EMPTY: input transfer -> ONE.
REQ-020: ONE: input and output transfer together -> ONE with new data; input only -> FULL, data into skid; output only -> EMPTY.
REQ-021: FULL: output transfer -> ONE, skid moves to output register; no input transfer is possible.
REQ-022: in_ready SHALL be 1 exactly when the skid register is empty (EMPTY or ONE), driven from a register, with no combinational path from out_ready.
REQ-023: Throughput SHALL be one transfer per cycle with out_ready held 1.
REQ-024: Output data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025: Order SHALL be preserved; no operand set is dropped or duplicated.
REQ-026: in_a, in_b and in_sel SHALL be ignored when in_valid=0.

Reset
REQ-027: rst_n low SHALL immediately force state EMPTY, out_valid=0, out_a=0, out_y=0, out_cin=0; in_ready SHALL be 1 after reset.
REQ-028: Reset asserted mid-operation SHALL discard all buffered operand sets; the first transfer after release SHALL follow REQ-019.

Structure
REQ-029: The state encoding and the S1S0 Y-select constants SHALL reside in a shared package, alu_pkg, also used by the parallel adder and the logic unit.
REQ-030: The B-input mapping SHALL be one combinational sub-module, b_input_logic (in_b, S1S0 -> Y), applied before the buffer registers.

Verification
REQ-031: in_a=0x7FFFFFFF, in_b=0x00000001, in_sel=010, out_ready=1 -> next cycle out_valid=1, out_y=0x00000001, out_cin=0.
REQ-032: in_a=0x00000005, in_b=0x00000003, in_sel=101 -> out_y=0xFFFFFFFC, out_cin=1 (adder yields A-B=2).
REQ-033: in_sel=110 then in_sel=001, any in_b -> out_y=0xFFFFFFFF, out_cin=0, then out_y=0x00000000, out_cin=1.
REQ-034: out_ready=0, send sets S1 then S2 -> in_ready=0 after S2; S1 held stable; raising out_ready yields S1 then S2 on consecutive cycles, in_ready=1 again.
REQ-035: out_ready=1 throughout, 8 back-to-back sets -> 8 outputs on 8 consecutive cycles, in order, in_ready never 0.
REQ-036: State FULL, rst_n pulsed low asynchronously between edges -> out_valid=0 and outputs 0 immediately; no stale sets appear after release.
